// File: rtl/prog_loader16.sv
// Byte-stream program loader: receives a counted, checksummed word stream and
// writes it into 16-bit program memory while holding the CPU core stopped.
module prog_loader16 #(
  parameter int          UUID      = 0,
  parameter string       NAME      = "",
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [3:0] {
    IDLE, CNT_LO, CNT_HI, DAT_LO, DAT_HI, WRITE, CHK, DONE, ERR
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  lo_q, lo_d;

  // Identity parameters are carried for hierarchy tooling only.
  if (UUID < 0 && NAME == "") begin : g_ident
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 16'h0000;
      idx_q   <= 16'h0000;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      acc_q   <= 8'h00;
      lo_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = CNT_LO;
          idx_d   = 16'h0000;
          acc_d   = 8'h00;
        end
      end
      CNT_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cnt_d[7:0] = in_data;
          acc_d      = acc_q ^ in_data;
          state_d    = CNT_HI;
        end
      end
      CNT_HI: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cnt_d[15:8] = in_data;
          acc_d       = acc_q ^ in_data;
          state_d     = ({in_data, cnt_q[7:0]} == 16'h0000) ? CHK : DAT_LO;
        end
      end
      DAT_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          lo_d    = in_data;
          acc_d   = acc_q ^ in_data;
          state_d = DAT_HI;
        end
      end
      DAT_HI: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Address and data are latched here so they stay put after the strobe.
          wdata_d = {in_data, lo_q};
          addr_d  = BASE_ADDR + idx_q;
          acc_d   = acc_q ^ in_data;
          state_d = WRITE;
        end
      end
      WRITE: begin
        idx_d   = idx_q + 16'd1;
        state_d = ((idx_q + 16'd1) == cnt_q) ? CHK : DAT_LO;
      end
      CHK: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = (in_data == acc_q) ? DONE : ERR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_we    = (state_q == WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_hold  = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);
  assign error     = (state_q == ERR);

endmodule

// File: doc/prog_loader16.md
PROG_LOADER16 -- requirements
Module: prog_loader16

Interface
REQ-001 The block SHALL have parameter UUID, default 0, instance identifier XORed into child UUIDs.
REQ-002 The block SHALL have parameter NAME, default "", instance label, no functional effect.
REQ-003 The block SHALL have parameter BASE_ADDR, default 16'h0000, program-memory address of the first loaded word.
REQ-004 clk  input  1  single clock, all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  begin a load session; sampled in IDLE, DONE, ERR.
REQ-007 in_valid  input  1  byte-stream source has a byte.
REQ-008 in_data  input  8  byte-stream data.
REQ-009 in_ready  output  1  loader accepts a byte; transfer occurs when in_valid and in_ready are both high at a rising edge.
REQ-010 mem_we  output  1  program-memory write strobe, one cycle per word.
REQ-011 mem_addr  output  16  program-memory write address.
REQ-012 mem_wdata  output  16  program-memory write data.
REQ-013 cpu_hold  output  1  holds the 16-bit CPU core stopped while memory is being written.
REQ-014 done  output  1  load completed with good checksum.
REQ-015 error  output  1  load failed on checksum.

Function
REQ-016 Stream format SHALL be: count low byte, count high byte, then count words each sent low byte first, then one checksum byte equal to the XOR of all preceding bytes of the session.
REQ-017 States SHALL be IDLE, CNT_LO, CNT_HI, DAT_LO, DAT_HI, WRITE, CHK, DONE, ERR.
REQ-018 IDLE/DONE/ERR with start=1 SHALL go to CNT_LO next cycle, clearing word index, checksum accumulator, done and error.
REQ-019 start SHALL be ignored in every other state.
REQ-020 in_ready SHALL be 1 exactly in CNT_LO, CNT_HI, DAT_LO, DAT_HI, CHK; each accepted byte advances one state and XORs into the accumulator (except in CHK).
REQ-021 CNT_HI SHALL go to CHK when the 16-bit count is 0, else to DAT_LO.
REQ-022 DAT_HI byte acceptance SHALL go to WRITE; WRITE lasts exactly one cycle with mem_we=1, mem_wdata={high byte, low byte}, mem_addr=BASE_ADDR+index modulo 2^16.
REQ-023 WRITE SHALL increment index and go to CHK when index+1 equals count, else to DAT_LO.
REQ-024 Count 65535 SHALL be supported; address arithmetic SHALL wrap silently past 16'hFFFF.
REQ-025 CHK SHALL go to DONE if received byte equals accumulator, else to ERR.
REQ-026 mem_we SHALL be 0 outside WRITE; mem_addr and mem_wdata SHALL hold their last values when mem_we=0.
REQ-027 cpu_hold SHALL be 1 in CNT_LO through CHK and in ERR; 0 in IDLE and DONE.
REQ-028 done SHALL be 1 only in DONE; error SHALL be 1 only in ERR.
REQ-029 in_valid low SHALL stall the FSM indefinitely with no timeout.

Reset
REQ-030 rst=0 SHALL asynchronously force IDLE, index 0, accumulator 0, in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_hold 0, done 0, error 0.
REQ-031 Reset asserted mid-load SHALL abort the session with no further write; a partially written memory is not rolled back.
REQ-032 After rst rises the block SHALL stay in IDLE until start.

Verification
REQ-033 Bytes 02 00 34 12 FF FF 24 after start -> writes 0x1234 @0x0000, 0xFFFF @0x0001, each mem_we one cycle; done=1, cpu_hold=0.
REQ-034 Same stream with checksum 25 -> both writes occur, then error=1, cpu_hold=1, done=0; start then re-enters CNT_LO with error=0.
REQ-035 Bytes 00 00 00 -> no mem_we, done=1; with checksum 01 -> error=1.
REQ-036 BASE_ADDR=16'hFFFF, one word 0xABCD (01 00 CD AB, chk 67) -> write @0xFFFF; second-word variant writes @0x0000.
REQ-037 in_valid toggled randomly plus start pulsed mid-load -> identical writes to back-to-back case, start ignored, in_ready=0 during WRITE.
REQ-038 rst=0 asserted between DAT_LO and DAT_HI -> all outputs 0 immediately, no write for that word.
